tt_counter_gen2: RTL and testbench

Parametrised successor to the team's fixed 8-bit Tiny Tapeout counter. It provides an up/down counter with a programmable terminal value, a clock prescaler, synchronous load and clear, and wrap or saturate boundary modes. It also drives a registered boundary tick and a sticky overflow flag. It sits directly behind the tt_um_ top-level pin mapping, with control on ui_in/uio_in and count on uo_out.

---
 rtl/tt_counter_gen2.sv | 92 +++++++++
 tb/tb_tt_counter_gen2.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/tt_counter_gen2.sv
// Parametrised up/down counter with terminal value, prescaler, load/clear,
// wrap or saturate boundary handling, registered wrap tick and sticky overflow.
module tt_counter_gen2 #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4,
  parameter int unsigned RESET_VAL  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  count_en,
  input  logic                  up_dn,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      top,
  input  logic                  sat_mode,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tick,
  output logic                  ovf,
  output logic                  at_top,
  output logic                  at_zero
);

  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);

  logic [PRESCALE_W-1:0] pc, pc_d;
  logic [WIDTH-1:0]      count_d;
  logic                  tick_d, ovf_d;
  logic                  step;

  assign step = count_en && (pc == prescale);

  always_comb begin
    count_d = count;
    pc_d    = pc;
    tick_d  = 1'b0;
    ovf_d   = ovf;
    if (!ena) begin
      // Frozen: registers hold, tick falls back to 0.
    end else if (clr) begin
      count_d = '0;
      pc_d    = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = load_val;
      pc_d    = '0;
      ovf_d   = 1'b0;
    end else if (count_en) begin
      pc_d = step ? '0 : pc + PRESCALE_W'(1);
      if (step) begin
        if (up_dn) begin
          if (count < top) begin
            count_d = count + WIDTH'(1);
          end else begin
            // Boundary also covers a loaded value above top.
            count_d = sat_mode ? top : '0;
            tick_d  = !sat_mode;
            ovf_d   = 1'b1;
          end
        end else begin
          if (count != '0) begin
            count_d = (sat_mode && (count > top)) ? top : count - WIDTH'(1);
          end else begin
            count_d = sat_mode ? '0 : top;
            tick_d  = !sat_mode;
            ovf_d   = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RST_COUNT;
      pc    <= '0;
      tick  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_d;
      pc    <= pc_d;
      tick  <= tick_d;
      ovf   <= ovf_d;
    end
  end

  assign at_top  = (count == top);
  assign at_zero = (count == '0);

endmodule

// File: tb/tb_tt_counter_gen2.sv
// Directed bench for tt_counter_gen2: expected outputs are queued as each step
// is driven and popped/checked one clock later.
module tb_tt_counter_gen2;

  logic       clk = 1'b0;
  logic       rst_n, ena, count_en, up_dn, clr, load, sat_mode;
  logic [7:0] load_val, top;
  logic [3:0] prescale;
  logic [7:0] count;
  logic       tick, ovf, at_top, at_zero;

  typedef struct {
    string      tag;
    logic [7:0] count;
    logic       tick;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  tt_counter_gen2 #(
    .WIDTH(8),
    .PRESCALE_W(4),
    .RESET_VAL(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .count_en(count_en),
    .up_dn(up_dn),
    .clr(clr),
    .load(load),
    .load_val(load_val),
    .top(top),
    .sat_mode(sat_mode),
    .prescale(prescale),
    .count(count),
    .tick(tick),
    .ovf(ovf),
    .at_top(at_top),
    .at_zero(at_zero)
  );

  always #5 clk = ~clk;

  task automatic check_out();
    exp_t e;
    logic et, ez;
    e  = sb.pop_front();
    et = (e.count == top);
    ez = (e.count == 8'h00);
    n_vec++;
    assert (count === e.count) else begin
      n_err++;
      $error("FAIL %s count: got %h expected %h", e.tag, count, e.count);
    end
    assert (tick === e.tick) else begin
      n_err++;
      $error("FAIL %s tick: got %b expected %b", e.tag, tick, e.tick);
    end
    assert (ovf === e.ovf) else begin
      n_err++;
      $error("FAIL %s ovf: got %b expected %b", e.tag, ovf, e.ovf);
    end
    assert (at_top === et) else begin
      n_err++;
      $error("FAIL %s at_top: got %b expected %b", e.tag, at_top, et);
    end
    assert (at_zero === ez) else begin
      n_err++;
      $error("FAIL %s at_zero: got %b expected %b", e.tag, at_zero, ez);
    end
  endtask

  task automatic check_now(input string tag, input logic [7:0] c, input logic t, input logic o);
    sb.push_back('{tag, c, t, o});
    check_out();
  endtask

  task automatic cycle(input string tag, input logic [7:0] c, input logic t, input logic o);
    sb.push_back('{tag, c, t, o});
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    logic [7:0] sat_seq [9];
    sat_seq = '{8'd2, 8'd2, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};

    rst_n = 1'b0; ena = 1'b1; count_en = 1'b0; up_dn = 1'b1; clr = 1'b0;
    load = 1'b0; sat_mode = 1'b0; load_val = 8'h00; top = 8'hFF; prescale = 4'd0;
    #12;
    check_now("reset", 8'h00, 1'b0, 1'b0);

    // Count up to 0x37, then reset between edges
    rst_n = 1'b1; count_en = 1'b1;
    for (int i = 1; i <= 8'h37; i++) cycle("up", 8'(i), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_now("rst_mid", 8'h00, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    cycle("resume", 8'h01, 1'b0, 1'b0);

    // Wrap up with top=9
    top = 8'd9; clr = 1'b1;
    cycle("clr", 8'h00, 1'b0, 1'b0);
    clr = 1'b0;
    for (int i = 1; i <= 9; i++) cycle("wrap_up", 8'(i), 1'b0, 1'b0);
    cycle("wrap_evt", 8'h00, 1'b1, 1'b1);
    cycle("wrap_after", 8'h01, 1'b0, 1'b1);

    // Saturating down count with prescale=2
    prescale = 4'd2; up_dn = 1'b0; sat_mode = 1'b1; load = 1'b1; load_val = 8'h02;
    cycle("sat_load", 8'h02, 1'b0, 1'b0);
    load = 1'b0;
    for (int i = 0; i < 9; i++) cycle("sat_dn", sat_seq[i], 1'b0, (i == 8) ? 1'b1 : 1'b0);
    for (int i = 0; i < 3; i++) cycle("sat_hold", 8'h00, 1'b0, 1'b1);

    // clr beats load beats boundary step
    prescale = 4'd0; clr = 1'b1; load = 1'b1; load_val = 8'h55;
    cycle("prio", 8'h00, 1'b0, 1'b0);
    clr = 1'b0;
    cycle("load55", 8'h55, 1'b0, 1'b0);

    // Loaded value above top
    top = 8'h10; load_val = 8'h20; count_en = 1'b0;
    cycle("ld20a", 8'h20, 1'b0, 1'b0);
    load = 1'b0; count_en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
    cycle("abv_wrap", 8'h00, 1'b1, 1'b1);
    load = 1'b1;
    cycle("ld20b", 8'h20, 1'b0, 1'b0);
    load = 1'b0; sat_mode = 1'b1;
    cycle("abv_sat", 8'h10, 1'b0, 1'b1);
    load = 1'b1;
    cycle("ld20c", 8'h20, 1'b0, 1'b0);
    load = 1'b0; up_dn = 1'b0;
    cycle("abv_dn", 8'h10, 1'b0, 1'b0);

    // ena gating keeps prescaler phase and forces tick low
    top = 8'h01; prescale = 4'd1; up_dn = 1'b1; sat_mode = 1'b0; load = 1'b1; load_val = 8'h01;
    cycle("ld1", 8'h01, 1'b0, 1'b0);
    load = 1'b0;
    cycle("ph1", 8'h01, 1'b0, 1'b0);
    cycle("ph_wrap", 8'h00, 1'b1, 1'b1);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) cycle("ena_off", 8'h00, 1'b0, 1'b1);
    ena = 1'b1;
    cycle("ena_p0", 8'h00, 1'b0, 1'b1);
    cycle("ena_step", 8'h01, 1'b0, 1'b1);
    cycle("ena_p1", 8'h01, 1'b0, 1'b1);
    cycle("ena_wrap", 8'h00, 1'b1, 1'b1);

    // top=0: every step wraps in place
    top = 8'h00; prescale = 4'd0;
    cycle("top0_a", 8'h00, 1'b1, 1'b1);
    cycle("top0_b", 8'h00, 1'b1, 1'b1);
    count_en = 1'b0;
    cycle("top0_hold", 8'h00, 1'b0, 1'b1);

    n_vec++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL sb_drain: got %0d entries expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
